// File: rtl/wisc_pkg.sv
// Shared branch-unit definitions: condition codes, flag bit positions,
// and helpers that map a condition code to the flags it reads and to its outcome.
package wisc_pkg;

   typedef enum logic [2:0] {
      CCC_NEQ    = 3'b000,
      CCC_EQ     = 3'b001,
      CCC_GT     = 3'b010,
      CCC_LT     = 3'b011,
      CCC_GTE    = 3'b100,
      CCC_LTE    = 3'b101,
      CCC_OVFL   = 3'b110,
      CCC_UNCOND = 3'b111
   } ccc_e;

   localparam int FLAG_N = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 2;

   // Flags a condition depends on; a branch may only resolve once none of these is in flight.
   function automatic logic [2:0] need_mask(ccc_e ccc);
      logic [2:0] m;
      m = '0;
      case (ccc)
         CCC_NEQ, CCC_EQ:           m[FLAG_Z] = 1'b1;
         CCC_LT:                    m[FLAG_N] = 1'b1;
         CCC_GT, CCC_GTE, CCC_LTE: begin
            m[FLAG_Z] = 1'b1;
            m[FLAG_N] = 1'b1;
         end
         CCC_OVFL:                  m[FLAG_V] = 1'b1;
         default:                   m = '0;
      endcase
      return m;
   endfunction

   // Outcome of a condition given the current flag register.
   function automatic logic cond_true(ccc_e ccc, logic [2:0] f);
      logic z, v, n, t;
      z = f[FLAG_Z];
      v = f[FLAG_V];
      n = f[FLAG_N];
      t = 1'b0;
      case (ccc)
         CCC_NEQ:    t = ~z;
         CCC_EQ:     t = z;
         CCC_GT:     t = ~z & ~n;
         CCC_LT:     t = n;
         CCC_GTE:    t = z | ~n;
         CCC_LTE:    t = z | n;
         CCC_OVFL:   t = v;
         default:    t = 1'b1;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/flag_scoreboard.sv
// Tracks flag writes still in flight. A mask issued this cycle stays pending
// for FLAG_LAT cycles: the current cycle (bypassed) plus FLAG_LAT-1 history stages.
module flag_scoreboard #(
   parameter int FLAG_LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] issue,
   output logic [2:0] pending
);

   generate
      if (FLAG_LAT <= 1) begin : g_bypass
         assign pending = issue;
      end else begin : g_shift
         logic [2:0] hist [FLAG_LAT-1];

         // Shift issued masks down the history, one stage per cycle.
         always_ff @(posedge clk) begin
            // NOTE: this is a handful of flops, not a RAM; clearing it on reset is
            // required so stale in-flight writes never stall the first branch.
            if (rst) begin
               for (int i = 0; i < FLAG_LAT-1; i++) hist[i] <= '0;
            end else begin
               hist[0] <= issue;
               for (int i = 1; i < FLAG_LAT-1; i++) hist[i] <= hist[i-1];
            end
         end

         // Pending is the union of live history and this cycle's issue.
         always_comb begin
            pending = issue;
            for (int i = 0; i < FLAG_LAT-1; i++) pending = pending | hist[i];
         end
      end
   endgenerate

endmodule

// File: rtl/branch_flag_reader.sv
// Branch resolution unit: holds one branch until the flags it reads are no
// longer in flight, then evaluates the condition and emits a one-cycle result.
module branch_flag_reader
   import wisc_pkg::*;
#(
   parameter int FLAG_LAT = 2,
   parameter int PC_W     = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [2:0]      br_ccc,
   input  logic            br_is_reg,
   input  logic [8:0]      br_imm,
   input  logic [PC_W-1:0] br_reg,
   input  logic [PC_W-1:0] br_pc_next,
   input  logic [2:0]      flag_q,
   input  logic [2:0]      flag_issue,
   input  logic            flush,
   output logic            res_valid,
   output logic            res_taken,
   output logic [PC_W-1:0] res_target
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_e;

   state_e          state_q, state_d;
   logic            accept, fire, stall, taken;
   logic [2:0]      pending;
   ccc_e            ccc_q;
   logic            is_reg_q;
   logic [8:0]      imm_q;
   logic [PC_W-1:0] reg_q, pc_next_q;
   logic [PC_W-1:0] offset, taken_target;

   flag_scoreboard #(.FLAG_LAT(FLAG_LAT)) u_sb (
      .clk     (clk),
      .rst     (rst),
      .issue   (flag_issue),
      .pending (pending)
   );

   assign br_ready     = (state_q == ST_IDLE) && !flush;
   assign stall        = |(pending & need_mask(ccc_q));
   assign taken        = cond_true(ccc_q, flag_q);
   assign offset       = {{(PC_W-9){imm_q[8]}}, imm_q} << 1;
   assign taken_target = is_reg_q ? reg_q : (pc_next_q + offset);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and control: accept in IDLE, resolve in WAIT once unblocked; flush wins.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      state_d = state_q;
      accept  = 1'b0;
      fire    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (br_valid && !flush) begin
               accept  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (!stall) begin
               fire    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture branch fields on accept; register the result when the branch resolves.
   always_ff @(posedge clk) begin
      if (rst) begin
         ccc_q      <= CCC_NEQ;
         is_reg_q   <= 1'b0;
         imm_q      <= '0;
         reg_q      <= '0;
         pc_next_q  <= '0;
         res_valid  <= 1'b0;
         res_taken  <= 1'b0;
         res_target <= '0;
      end else begin
         res_valid <= fire;
         if (accept) begin
            ccc_q     <= ccc_e'(br_ccc);
            is_reg_q  <= br_is_reg;
            imm_q     <= br_imm;
            reg_q     <= br_reg;
            pc_next_q <= br_pc_next;
         end
         if (fire) begin
            res_taken  <= taken;
            res_target <= taken ? taken_target : pc_next_q;
         end
      end
   end

endmodule

// File: tb/tb_branch_flag_reader.sv
// Directed bench for branch_flag_reader with a timestamp-based reference model
// checked every cycle, plus literal expectations at key points of each scenario.
module tb_branch_flag_reader;

   localparam int LAT = 3;
   localparam int PW  = 16;

   logic          clk = 1'b0;
   logic          rst, br_valid, br_ready, br_is_reg, flush;
   logic [2:0]    br_ccc, flag_q, flag_issue;
   logic [8:0]    br_imm;
   logic [PW-1:0] br_reg, br_pc_next;
   logic          res_valid, res_taken;
   logic [PW-1:0] res_target;

   int total = 0;
   int bad   = 0;

   branch_flag_reader #(.FLAG_LAT(LAT), .PC_W(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .br_valid   (br_valid),
      .br_ready   (br_ready),
      .br_ccc     (br_ccc),
      .br_is_reg  (br_is_reg),
      .br_imm     (br_imm),
      .br_reg     (br_reg),
      .br_pc_next (br_pc_next),
      .flag_q     (flag_q),
      .flag_issue (flag_issue),
      .flush      (flush),
      .res_valid  (res_valid),
      .res_taken  (res_taken),
      .res_target (res_target)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] c, input logic isr, input logic [8:0] imm,
                        input logic [15:0] rg, input logic [15:0] pcn);
      br_ccc     = c;
      br_is_reg  = isr;
      br_imm     = imm;
      br_reg     = rg;
      br_pc_next = pcn;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [2:0] m_need(input logic [2:0] c);
      case (c)
         3'd0, 3'd1:       return 3'b100;
         3'd3:             return 3'b001;
         3'd2, 3'd4, 3'd5: return 3'b101;
         3'd6:             return 3'b010;
         default:          return 3'b000;
      endcase
   endfunction

   function automatic logic m_cond(input logic [2:0] c, input logic [2:0] f);
      logic z, v, n;
      z = f[2]; v = f[1]; n = f[0];
      case (c)
         3'd0:    return !z;
         3'd1:    return z;
         3'd2:    return !z && !n;
         3'd3:    return n;
         3'd4:    return z || !n;
         3'd5:    return z || n;
         3'd6:    return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [15:0] m_target(input logic tk, input logic isr, input logic [8:0] imm,
                                            input logic [15:0] rg, input logic [15:0] pcn);
      int off;
      if (!tk) return pcn;
      if (isr) return rg;
      off = int'($signed(imm));
      return 16'(int'(pcn) + off * 2);
   endfunction

   // Model state: one held branch, and the cycle at which each flag was last issued.
   int          cyc = 0;
   int          last_iss [3] = '{-1000, -1000, -1000};
   bit          started = 0;
   bit          m_busy = 0, m_rv = 0, m_rt = 0;
   logic [15:0] m_rtgt = '0;
   logic [2:0]  m_ccc;
   logic        m_isr;
   logic [8:0]  m_imm;
   logic [15:0] m_reg, m_pcn;

   always @(posedge clk) begin
      logic [2:0] pend;
      started = 1;
      if (rst) begin
         m_busy = 0; m_rv = 0; m_rt = 0; m_rtgt = '0;
         for (int b = 0; b < 3; b++) last_iss[b] = -1000;
      end else begin
         for (int b = 0; b < 3; b++) if (flag_issue[b]) last_iss[b] = cyc;
         for (int b = 0; b < 3; b++) pend[b] = (cyc - last_iss[b]) < LAT;
         m_rv = 0;
         if (m_busy) begin
            if (flush) begin
               m_busy = 0;
            end else if ((pend & m_need(m_ccc)) == 3'b000) begin
               m_rv   = 1;
               m_rt   = m_cond(m_ccc, flag_q);
               m_rtgt = m_target(m_rt, m_isr, m_imm, m_reg, m_pcn);
               m_busy = 0;
            end
         end else if (br_valid && !flush) begin
            m_busy = 1;
            m_ccc = br_ccc; m_isr = br_is_reg; m_imm = br_imm; m_reg = br_reg; m_pcn = br_pc_next;
         end
      end
      cyc++;
   end

   // Compare DUT against the model every cycle, mid-period.
   always @(negedge clk) begin
      if (started) begin
         check("m_ready", 32'(br_ready), 32'(!m_busy && !flush));
         check("m_res_valid", 32'(res_valid), 32'(m_rv));
         check("m_res_taken", 32'(res_taken), 32'(m_rt));
         check("m_res_target", 32'(res_target), 32'(m_rtgt));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1; br_valid = 0; flush = 0; flag_q = '0; flag_issue = '0;
      drive(3'd0, 1'b0, 9'd0, 16'h0, 16'h0);
      tick(); tick();
      check("rst_valid", 32'(res_valid), 0);
      check("rst_taken", 32'(res_taken), 0);
      check("rst_target", 32'(res_target), 0);
      check("rst_ready", 32'(br_ready), 1);
      rst = 0;

      // EQ with Z=1, nothing pending: result two cycles after accept.
      drive(3'd1, 1'b0, 9'd4, 16'h0, 16'h0010); flag_q = 3'b100; br_valid = 1;
      tick(); br_valid = 0;
      check("t1_wait", 32'(res_valid), 0);
      tick();
      check("t1_valid", 32'(res_valid), 1);
      check("t1_taken", 32'(res_taken), 1);
      check("t1_target", 32'(res_target), 'h0018);
      tick();
      check("t1_pulse", 32'(res_valid), 0);
      check("t1_hold", 32'(res_target), 'h0018);

      // NEQ with Z issued in the accept cycle: stalls, resolves on updated flag_q.
      drive(3'd0, 1'b0, 9'h1FD, 16'h0, 16'h0100); flag_q = 3'b100; flag_issue = 3'b100; br_valid = 1;
      tick(); br_valid = 0; flag_issue = 3'b000;
      for (int i = 0; i < LAT - 1; i++) begin
         tick();
         check("t2_stall", 32'(res_valid), 0);
      end
      flag_q = 3'b000;
      tick();
      check("t2_valid", 32'(res_valid), 1);
      check("t2_taken", 32'(res_taken), 1);
      check("t2_target", 32'(res_target), 'h00FA);
      tick();

      // LT with only V pending: no stall; register target.
      drive(3'd3, 1'b1, 9'd0, 16'hBEEF, 16'h0200); flag_q = 3'b001; flag_issue = 3'b010; br_valid = 1;
      tick(); br_valid = 0; flag_issue = 3'b000;
      tick();
      check("t3_valid", 32'(res_valid), 1);
      check("t3_target", 32'(res_target), 'hBEEF);
      tick();

      // LTE not taken: target is pc_next.
      drive(3'd5, 1'b0, 9'd5, 16'h0, 16'h0222); flag_q = 3'b000; br_valid = 1;
      tick(); br_valid = 0;
      tick();
      check("t3b_taken", 32'(res_taken), 0);
      check("t3b_target", 32'(res_target), 'h0222);
      tick();

      // Unconditional wrap, then register form.
      drive(3'd7, 1'b0, 9'd1, 16'h0, 16'hFFFE); br_valid = 1;
      tick(); br_valid = 0;
      tick();
      check("t4_wrap", 32'(res_target), 'h0000);
      tick();
      drive(3'd7, 1'b1, 9'd1, 16'h1234, 16'hFFFE); br_valid = 1;
      tick(); br_valid = 0;
      tick();
      check("t4_reg", 32'(res_target), 'h1234);
      tick();

      // OVFL taken with most negative offset.
      drive(3'd6, 1'b0, 9'h100, 16'h0, 16'h0500); flag_q = 3'b010; br_valid = 1;
      tick(); br_valid = 0;
      tick();
      check("t4_ovfl_taken", 32'(res_taken), 1);
      check("t4_ovfl_target", 32'(res_target), 'h0300);
      tick();

      // Flush wins over a resolving UNCOND; scoreboard survives the flush.
      drive(3'd7, 1'b0, 9'd2, 16'h0, 16'h0400); br_valid = 1;
      tick(); br_valid = 0; flush = 1; flag_issue = 3'b100; #1;
      check("t5_ready_flush", 32'(br_ready), 0);
      tick(); flush = 0; flag_issue = 3'b000; #1;
      check("t5_no_valid", 32'(res_valid), 0);
      check("t5_ready", 32'(br_ready), 1);
      drive(3'd1, 1'b0, 9'd8, 16'h0, 16'h0300); flag_q = 3'b100; br_valid = 1;
      tick(); br_valid = 0;
      tick();
      check("t5_stall", 32'(res_valid), 0);
      tick();
      check("t5_valid", 32'(res_valid), 1);
      check("t5_target", 32'(res_target), 'h0310);
      tick();

      // Reset mid-WAIT drops the branch; br_valid held across deassert is accepted at once.
      drive(3'd1, 1'b0, 9'd0, 16'h0, 16'h0600); flag_issue = 3'b100; br_valid = 1;
      tick(); flag_issue = 3'b000; rst = 1;
      drive(3'd7, 1'b0, 9'd0, 16'h0, 16'h0040);
      tick();
      check("t6_rst_valid", 32'(res_valid), 0);
      check("t6_rst_taken", 32'(res_taken), 0);
      check("t6_rst_target", 32'(res_target), 0);
      tick(); rst = 0; #1;
      check("t6_ready", 32'(br_ready), 1);
      tick(); br_valid = 0;
      check("t6_accept_wait", 32'(res_valid), 0);
      tick();
      check("t6_valid", 32'(res_valid), 1);
      check("t6_target", 32'(res_target), 'h0040);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_flag_reader.md
BRANCH_FLAG_READER -- requirements
Module: branch_flag_reader

Interface
REQ-001 Parameter FLAG_LAT, default 2, meaning: cycles from flag-write issue until the value shows on flag_q (legal 1..3).
REQ-002 Parameter PC_W, default 16, meaning: PC and target width.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 br_valid  in  1  branch request from decode.
REQ-006 br_ready  out  1  unit can accept a request.
REQ-007 br_ccc  in  3  condition code: 000 NEQ, 001 EQ, 010 GT, 011 LT, 100 GTE, 101 LTE, 110 OVFL, 111 UNCOND.
REQ-008 br_is_reg  in  1  1 = register target (BR), 0 = PC-relative (B).
REQ-009 br_imm  in  9  signed word offset.
REQ-010 br_reg  in  PC_W  register target value.
REQ-011 br_pc_next  in  PC_W  PC+2 of the branch.
REQ-012 flag_q  in  3  flag register output: [2]=Z, [1]=V, [0]=N.
REQ-013 flag_issue  in  3  per-flag write-enable mask of the older instruction entering execute this cycle.
REQ-014 flush  in  1  abandon any held branch.
REQ-015 res_valid  out  1  one-cycle resolution pulse.
REQ-016 res_taken  out  1  condition true.
REQ-017 res_target  out  PC_W  next PC.

Function
REQ-018 States IDLE and WAIT only. br_ready = 1 exactly when state is IDLE and flush = 0.
REQ-019 Accept happens on br_valid & br_ready. The unit captures ccc, is_reg, imm, reg and pc_next, then enters WAIT.
REQ-020 Scoreboard: flag_issue mask m at cycle t keeps bits m pending during cycles t .. t+FLAG_LAT-1. pending = OR of all live entries plus the current flag_issue.
REQ-021 Needed flags per condition: NEQ/EQ need Z; LT needs N; GT/GTE/LTE need Z,N; OVFL needs V; UNCOND needs none.
REQ-022 In WAIT at cycle c: if (pending & need) == 0, evaluate using flag_q of cycle c, assert res_valid at c+1, and return to IDLE at c+1. Otherwise stay in WAIT.
REQ-023 Conditions: NEQ Z=0; EQ Z=1; GT Z=0&N=0; LT N=1; GTE Z=1|N=0; LTE Z=1|N=1; OVFL V=1; UNCOND 1.
REQ-024 res_target = pc_next when not taken. When taken: br_reg if is_reg, else pc_next + (sext(imm)<<1), modulo 2^PC_W (wrap, no error).
REQ-025 Minimum latency is accept at t, evaluate at t+1, res_valid at t+2. Maximum latency is t+1+FLAG_LAT.
REQ-026 res_valid is high for exactly one cycle per accepted, unflushed branch. res_taken and res_target hold their value until the next res_valid.
REQ-027 A flag_issue in the same cycle as accept counts as older and pending.
REQ-028 flush = 1 forces IDLE next cycle with no res_valid, and blocks any accept that cycle. It does not clear the scoreboard, because older writes still land.
REQ-029 A flush in the same cycle the branch evaluates wins: no res_valid.

Reset
REQ-030 On rst: state IDLE, scoreboard cleared, res_valid=0, res_taken=0, res_target=0, captured fields 0.
REQ-031 rst mid-WAIT drops the branch silently. br_ready=1 the cycle after rst deasserts.

Structure
REQ-032 Shared package wisc_pkg holds the ccc enum, flag bit indices (FLAG_N=0, FLAG_V=1, FLAG_Z=2) and the need-mask function.
REQ-033 Sub-module flag_scoreboard is a FLAG_LAT-deep shift of 3-bit masks that outputs the pending mask.

Verification
REQ-034 No pending; ccc=001; flag_q=100; pc_next=0x0010; imm=+4 -> res_valid 2 cycles after accept, taken=1, target=0x0018.
REQ-035 flag_issue=100 in the accept cycle; ccc=000 -> stays in WAIT, res_valid at accept+1+FLAG_LAT, evaluated on the updated flag_q.
REQ-036 flag_issue=010 pending; ccc=011 (needs N only) -> no stall, res_valid at accept+2.
REQ-037 pc_next=0xFFFE, imm=+1, ccc=111 -> target=0x0000 (wrap). Same case with is_reg=1, br_reg=0x1234 -> target=0x1234.
REQ-038 flush asserted in a WAIT cycle -> no res_valid; br_ready=1 next cycle; a pending scoreboard entry still blocks a new Z-dependent branch.
REQ-039 rst during WAIT -> all outputs 0, no res_valid. br_valid held high across rst deassert -> accepted in the first cycle after rst deasserts.
